// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the register bus widths, the arbiter defaults and the reset polarity.
package regfile_wport_arbiter_pkg;

  localparam int RegAddrW   = 5;
  localparam int RegDataW   = 32;
  localparam int RegNumLog2 = 5;

  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam int ArbStarveMax = 4;
  localparam int ArbFifoDepth = 2;

  localparam logic RstEnable_n  = 1'b0;
  localparam logic RstDisable_n = 1'b1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wq_fifo.sv
// Queue of pending long-latency register writes, drained in arrival order.
// Also answers "is this address still waiting to be written?" for two lookups.
module regfile_wq_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH  = ArbFifoDepth,
  parameter int ADDR_W = RegAddrW,
  parameter int DATA_W = RegDataW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [ADDR_W-1:0]       push_addr_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [ADDR_W-1:0]       head_addr_o,
  output logic [DATA_W-1:0]       head_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [$clog2(DEPTH):0]  count_next_o,
  input  logic [ADDR_W-1:0]       match_addr1_i,
  input  logic [ADDR_W-1:0]       match_addr2_i,
  output logic                    match1_o,
  output logic                    match2_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  live;

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        tail_d  = tail_q + PW'(1);
        count_d = count_q + CW'(1);
      end
      2'b01: begin
        head_d  = head_q + PW'(1);
        count_d = count_q - CW'(1);
      end
      2'b11: begin
        tail_d = tail_q + PW'(1);
        head_d = head_q + PW'(1);
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; stale slots are masked by the live vector, so no reset
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    live = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = ({1'b0, (PW'(i) - head_q)} < count_q);
    end
  end

  // Pending-address lookup against live slots only
  always_comb begin
    match1_o = 1'b0;
    match2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match1_o = match1_o | (live[i] && (addr_q[i] == match_addr1_i)
                             && (match_addr1_i != {ADDR_W{1'b0}}));
      match2_o = match2_o | (live[i] && (addr_q[i] == match_addr2_i)
                             && (match_addr2_i != {ADDR_W{1'b0}}));
    end
  end

  assign head_addr_o  = addr_q[head_q];
  assign head_data_o  = data_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register file write port: pipeline writeback wins, queued
// long-latency writes drain on free cycles, and starvation raises a stall.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH      = ArbFifoDepth,
  parameter int MAX_STARVE = ArbStarveMax,
  parameter int ADDR_W     = RegAddrW,
  parameter int DATA_W     = RegDataW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_waddr,
  input  logic [DATA_W-1:0]      wb_wdata,
  input  logic                   lu_valid,
  input  logic [ADDR_W-1:0]      lu_waddr,
  input  logic [DATA_W-1:0]      lu_wdata,
  output logic                   lu_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic                   pend1,
  output logic                   pend2,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] lu_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(MAX_STARVE + 1);

  grant_e            grant;
  logic              run;
  logic              wb_hold;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     fifo_count_next;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              match1;
  logic              match2;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  assign run        = (rst == RstDisable_n);
  assign wb_hold    = wb_we && (wb_waddr != {ADDR_W{1'b0}});
  assign fifo_empty = (fifo_count == {CW{1'b0}});
  assign lu_ready   = run && (fifo_count < CW'(DEPTH));
  // Address-0 requests complete the handshake but are dropped here
  assign push       = lu_valid && lu_ready && (lu_waddr != {ADDR_W{1'b0}});
  assign pop        = (grant == GRANT_FIFO);

  regfile_wq_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wq_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_addr_i   (lu_waddr),
    .push_data_i   (lu_wdata),
    .pop_i         (pop),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .count_o       (fifo_count),
    .count_next_o  (fifo_count_next),
    .match_addr1_i (raddr1),
    .match_addr2_i (raddr2),
    .match1_o      (match1),
    .match2_o      (match2)
  );

  // Port grant: writeback first, then queue head
  always_comb begin
    grant = GRANT_NONE;
    if (!run) begin
      grant = GRANT_NONE;
    end else if (wb_hold) begin
      grant = GRANT_WB;
    end else if (!fifo_empty) begin
      grant = GRANT_FIFO;
    end else begin
      grant = GRANT_NONE;
    end
  end

  // Write-port mux
  always_comb begin
    rf_we    = WriteDisable;
    rf_waddr = {ADDR_W{1'b0}};
    rf_wdata = {DATA_W{1'b0}};
    case (grant)
      GRANT_WB: begin
        rf_we    = WriteEnable;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
      GRANT_FIFO: begin
        rf_we    = WriteEnable;
        rf_waddr = head_addr;
        rf_wdata = head_data;
      end
      default: begin
        rf_we = WriteDisable;
      end
    endcase
  end

  // Starvation counter and stall request next-state
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (!fifo_empty && (grant == GRANT_WB)) begin
      starve_d = (starve_q == SW'(MAX_STARVE)) ? starve_q : (starve_q + SW'(1));
    end else begin
      starve_d = {SW{1'b0}};
    end
    if (starve_d == SW'(MAX_STARVE)) begin
      stall_d = 1'b1;
    end else if (fifo_count_next == {CW{1'b0}}) begin
      stall_d = 1'b0;
    end else begin
      stall_d = stall_q;
    end
  end

  // Starvation counter and stall request registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      starve_q <= {SW{1'b0}};
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_req = run && stall_q;
  assign pend1     = run && match1;
  assign pend2     = run && match2;
  assign lu_count  = run ? fifo_count : {CW{1'b0}};

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench: a queue-based model predicts each cycle's outputs and the
// register writes; a negedge monitor consumes expected writes as rf_we fires.
module tb_regfile_wport_arbiter;

  localparam int DEPTH      = 2;
  localparam int MAX_STARVE = 4;
  localparam int AW         = 5;
  localparam int DW         = 32;

  logic          clk = 1'b0;
  logic          rst, wb_we, lu_valid, lu_ready, rf_we, pend1, pend2, stall_req;
  logic [AW-1:0] wb_waddr, lu_waddr, rf_waddr, raddr1, raddr2;
  logic [DW-1:0] wb_wdata, lu_wdata, rf_wdata;
  logic [1:0]    lu_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t expq[$];
  wr_t mq[$];
  int  m_starve = 0;
  bit  m_stall  = 1'b0;
  wr_t mon_e;

  always #5 clk = ~clk;

  regfile_wport_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .lu_valid  (lu_valid),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .pend1     (pend1),
    .pend2     (pend2),
    .stall_req (stall_req),
    .lu_count  (lu_count)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the reference model; called at posedge+1 with inputs applied
  task automatic step();
    bit  hold, rdy, had, p1, p2, ewe;
    int  cnt;
    wr_t w;
    hold = 1'b0; rdy = 1'b0; p1 = 1'b0; p2 = 1'b0; ewe = 1'b0; cnt = 0;
    had  = (mq.size() > 0);
    if (rst) begin
      rdy  = (mq.size() < DEPTH);
      hold = wb_we && (wb_waddr != 0);
      cnt  = mq.size();
      foreach (mq[k]) begin
        if (raddr1 != 0 && mq[k].a == raddr1) p1 = 1'b1;
        if (raddr2 != 0 && mq[k].a == raddr2) p2 = 1'b1;
      end
      if (hold) begin
        w.a = wb_waddr; w.d = wb_wdata; ewe = 1'b1;
      end else if (had) begin
        w = mq[0]; ewe = 1'b1;
      end
      if (ewe) expq.push_back(w);
    end
    @(negedge clk);
    chk("lu_ready",  32'(lu_ready),  32'(rdy));
    chk("rf_we",     32'(rf_we),     32'(ewe));
    chk("stall_req", 32'(stall_req), 32'(rst ? m_stall : 1'b0));
    chk("lu_count",  32'(lu_count),  32'(cnt));
    chk("pend1",     32'(pend1),     32'(p1));
    chk("pend2",     32'(pend2),     32'(p2));
    if (!rst) begin
      mq.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      if (!hold && had) void'(mq.pop_front());
      m_starve = (had && hold) ? ((m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE) : 0;
      if (lu_valid && rdy && lu_waddr != 0) begin
        w.a = lu_waddr; w.d = lu_wdata;
        mq.push_back(w);
      end
      if (m_starve == MAX_STARVE) m_stall = 1'b1;
      else if (mq.size() == 0) m_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit r, input bit we, input int wa, input logic [31:0] wd,
                     input bit lv, input int la, input logic [31:0] ld,
                     input int r1, input int r2, input int n);
    rst      = r;
    wb_we    = we;
    wb_waddr = AW'(wa);
    wb_wdata = wd;
    lu_valid = lv;
    lu_waddr = AW'(la);
    lu_wdata = ld;
    raddr1   = AW'(r1);
    raddr2   = AW'(r2);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard consumer: every granted write must match the oldest expectation
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rf_unexpected: got write $%0d=%0h required none at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        mon_e = expq.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.a));
        chk("rf_wdata", rf_wdata, mon_e.d);
      end
    end else begin
      chk("rf_idle_waddr", 32'(rf_waddr), 32'd0);
      chk("rf_idle_wdata", rf_wdata, 32'd0);
    end
  end

  initial begin
    int pct;
    drv(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    // Reset held with live requests
    drv(1'b0, 1'b1, 3, 32'h1111_1111, 1'b1, 6, 32'h2222_2222, 6, 3, 2);
    // Idle port, single long-latency write with pending lookup
    drv(1'b1, 1'b0, 0, 32'h0, 1'b1, 8, 32'h1234_5678, 8, 0, 1);
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 8, 0, 3);
    // Starvation: wb hammers $3 while $9 waits
    drv(1'b1, 1'b1, 3, 32'h0000_0033, 1'b1, 9, 32'hA5A5_A5A5, 9, 3, 1);
    drv(1'b1, 1'b1, 3, 32'h0000_0034, 1'b0, 0, 32'h0, 9, 3, 5);
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 9, 0, 3);
    // Fill to depth while wb busy, then drain back-to-back
    drv(1'b1, 1'b1, 2, 32'h0000_0002, 1'b1, 4, 32'h0000_0044, 4, 5, 1);
    drv(1'b1, 1'b1, 2, 32'h0000_0002, 1'b1, 5, 32'h0000_0055, 4, 5, 1);
    drv(1'b1, 1'b1, 2, 32'h0000_0002, 1'b1, 6, 32'h0000_0066, 4, 5, 1);
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 4, 5, 3);
    // Address 0 handshake is discarded
    drv(1'b1, 1'b0, 0, 32'h0, 1'b1, 0, 32'hDEAD_BEEF, 0, 0, 1);
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 0, 2);
    // wb write to $0 leaves the port free for the queue
    drv(1'b1, 1'b1, 3, 32'h0000_0003, 1'b1, 7, 32'h0000_0077, 7, 0, 1);
    drv(1'b1, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 7, 0, 1);
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 7, 0, 2);
    // Reset mid-operation discards queued writes
    drv(1'b1, 1'b1, 2, 32'h0000_0002, 1'b1, 10, 32'h0000_00AA, 10, 11, 1);
    drv(1'b1, 1'b1, 2, 32'h0000_0002, 1'b1, 11, 32'h0000_00BB, 10, 11, 1);
    drv(1'b1, 1'b1, 2, 32'h0000_0002, 1'b0, 0, 32'h0, 10, 11, 2);
    drv(1'b0, 1'b1, 2, 32'h0000_0002, 1'b0, 0, 32'h0, 10, 11, 1);
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 10, 11, 5);
    // Randomised traffic with varying writeback load and rare resets
    pct = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 25 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 20;
          1:       pct = 60;
          default: pct = 95;
        endcase
      end
      drv(($urandom_range(0, 80) != 0),
          ($urandom_range(0, 99) < pct), $urandom_range(0, 15), $urandom(),
          ($urandom_range(0, 2) != 0), $urandom_range(0, 15), $urandom(),
          $urandom_range(0, 15), $urandom_range(0, 15), 1);
    end
    drv(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 0, 6);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between two requesters: the pipeline writeback stage and a long-latency unit (divider/load return) that writes back out of order.
- The pipeline has fixed priority. Long-latency writes queue in a small FIFO and drain on free port cycles.
- Provides pending-write flags for the ID stage's hazard check, and a stall request when queued writes starve.
- Sits between MEM/WB, the long-latency unit, and the register file write port.

Parameters:
DEPTH, 2, FIFO entries for long-latency writes (power of 2, >=2)
MAX_STARVE, 4, consecutive blocked cycles before stall_req is raised
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
wb_we  in  1  pipeline writeback enable
wb_waddr  in  ADDR_W  pipeline writeback address
wb_wdata  in  DATA_W  pipeline writeback data
lu_valid  in  1  long-latency write request
lu_waddr  in  ADDR_W  long-latency write address
lu_wdata  in  DATA_W  long-latency write data
lu_ready  out  1  FIFO can accept; transfer occurs when lu_valid && lu_ready
rf_we  out  1  register file write enable
rf_waddr  out  ADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
raddr1  in  ADDR_W  ID read/dest address 1 for hazard check
raddr2  in  ADDR_W  ID read/dest address 2 for hazard check
pend1  out  1  raddr1 matches a queued FIFO entry
pend2  out  1  raddr2 matches a queued FIFO entry
stall_req  out  1  request pipeline stall so the FIFO can drain
lu_count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0 sampled at a clock edge):
  - FIFO flushed; count, starve_cnt and stall_req cleared.
  - While rst=0, all outputs are forced to 0: lu_ready, rf_we, rf_waddr, rf_wdata, pend1/2, stall_req, lu_count.
  - Reset mid-operation discards queued writes; no rf_we occurs for them afterwards.
- lu_ready = (count < DEPTH), from registered count only.
  - A full FIFO does not accept in the same cycle it drains; lu_ready rises the cycle after the drain.
- Enqueue on lu_valid && lu_ready; the entry is visible from the next cycle. lu_waddr=0 is handshaked but discarded: not enqueued, never pending.
- Port grant each cycle (combinational; rf_* has zero latency):
  - wb_we=1 and wb_waddr!=0: pass the wb write through.
  - Else, FIFO non-empty: write the FIFO head and pop it at the clock edge.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
  - wb_we=1 with wb_waddr=0 counts as a free port.
- FIFO order is strict: first in, first written.
- Starvation:
  - starve_cnt increments (saturating at MAX_STARVE) at each edge where the FIFO is non-empty and the wb write held the port.
  - It clears on any drain or when the FIFO is empty.
  - stall_req is registered. It is set at the edge where starve_cnt reaches MAX_STARVE, and cleared at the edge where count becomes 0.
  - While stall_req=1, the pipeline bubbles WB. The arbiter never drops or delays a wb write.
- pend1/pend2: combinational compare of raddr1/raddr2 against valid registered FIFO entries.
  - Address 0 is never pending.
  - An entry draining this cycle still reports pending this cycle; the register file's same-address bypass covers it.
- Precondition: ID stalls on pend for destination addresses too, so wb and FIFO never hold the same address simultaneously. This is not checked by this block.
- Simultaneous enqueue and drain in one cycle (count < DEPTH): count unchanged.

Decomposition:
- Shared defines (defines.v):
  - Existing: RegAddrBus, RegBus, RegNumLog2, WriteEnable, ZeroWord.
  - New: ArbStarveMax (default 4) and ArbFifoDepth (default 2).
  - New reset-polarity constants: RstEnable_n = 1'b0, RstDisable_n = 1'b1.
- One natural sub-module: regfile_wq_fifo. It holds the FIFO storage, head/tail pointers and count, and exposes two address-match ports (pend lookup).
- The top level holds the grant mux, the starvation counter and stall_req.

Test Plan:
1. Hold rst=0 for 2 cycles with lu_valid=1, wb_we=1 -> lu_ready=0, rf_we=0, stall_req=0, pend1=pend2=0, lu_count=0.
2. Idle port. At cycle t, lu writes $8=0x12345678 -> at t+1, rf_we=1, rf_waddr=8, rf_wdata=0x12345678. With raddr1=8: pend1=1 at t+1 and 0 at t+2; lu_count returns to 0 at t+2.
3. wb_we=1 to $3 every cycle; lu enqueues $9=0xA5A5A5A5 at t:
   - rf_waddr=3 for t+1..t+4; stall_req=1 from t+5.
   - Drop wb_we at t+6 -> rf writes $9 at t+6; stall_req=0 at t+7.
4. wb busy and DEPTH=2. Enqueue $4 then $5 -> lu_ready=0 on the next cycle. Free the port -> rf writes $4 then $5 in consecutive cycles; lu_ready=1 the cycle after the first drain.
5. Two cases:
   - lu_waddr=0 handshake -> no rf_we, no pend, lu_count stays 0.
   - FIFO holds $7 with wb_we=1, wb_waddr=0 -> $7 is written that same cycle.
6. FIFO holds $10 and $11 with wb busy; pulse rst=0 for one cycle -> lu_count=0, stall_req=0, and no rf_we to $10/$11 in the following 5 idle cycles.
